// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core.
// Every pipeline stage imports this package so that widths and reset values agree.
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // The fetch stage picks exactly one of these actions on each clock edge.
    typedef enum logic [1:0] {
        FETCH_ADVANCE  = 2'd0,
        FETCH_STALL    = 2'd1,
        FETCH_REDIRECT = 2'd2
    } fetch_action_e;

    function automatic logic [WORD_W-1:0] wordAlign(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register that sits between the fetch stage and the decode stage.
// If more than one control input is active, flush wins over hold, and hold wins over load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic              hold,
    input  logic [WORD_W-1:0] instrIn,
    input  logic [WORD_W-1:0] pcPlus4In,
    output logic [WORD_W-1:0] instrOut,
    output logic [WORD_W-1:0] pcPlus4Out,
    output logic              validOut
);

    logic [WORD_W-1:0] instr_q;
    logic [WORD_W-1:0] pcPlus4_q;
    logic              valid_q;

    // A flush leaves a NOP bubble in the register, so decode sees a clean zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q   <= MIPS_NOP;
            pcPlus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            instr_q   <= MIPS_NOP;
            pcPlus4_q <= '0;
            valid_q   <= 1'b0;
        end else if (!hold && load) begin
            instr_q   <= instrIn;
            pcPlus4_q <= pcPlus4In;
            valid_q   <= 1'b1;
        end
    end

    assign instrOut   = instr_q;
    assign pcPlus4Out = pcPlus4_q;
    assign validOut   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux, sticky alignment fault
// and a saturating count of fetched instructions, feeding the IF/ID register.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] id_instr,
    output logic [WORD_W-1:0] id_pc_plus4,
    output logic              id_valid,
    output logic              align_fault,
    output logic [CNT_W-1:0]  fetch_count
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pcPlus4;
    logic              alignFault_q, alignFault_d;
    logic [CNT_W-1:0]  fetchCount_q, fetchCount_d;
    fetch_action_e     action;

    assign pcPlus4 = pc_q + WORD_W'(INSTR_BYTES);

    // A redirect overrides a stall, because the instruction the stall was holding is on the wrong path.
    always_comb begin
        action = FETCH_ADVANCE;
        if (redirect_valid) begin
            action = FETCH_REDIRECT;
        end else if (stall) begin
            action = FETCH_STALL;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        alignFault_d = alignFault_q;
        fetchCount_d = fetchCount_q;
        unique case (action)
            FETCH_REDIRECT: begin
                pc_d         = wordAlign(redirect_target);
                alignFault_d = alignFault_q | (redirect_target[1:0] != 2'b00);
            end
            FETCH_STALL: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d = pcPlus4;
                if (fetchCount_q != {CNT_W{1'b1}}) begin
                    fetchCount_d = fetchCount_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            alignFault_q <= 1'b0;
            fetchCount_q <= '0;
        end else begin
            pc_q         <= pc_d;
            alignFault_q <= alignFault_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .load       (action == FETCH_ADVANCE),
        .flush      (action == FETCH_REDIRECT),
        .hold       (action == FETCH_STALL),
        .instrIn    (imem_rdata),
        .pcPlus4In  (pcPlus4),
        .instrOut   (id_instr),
        .pcPlus4Out (id_pc_plus4),
        .validOut   (id_valid)
    );

    assign imem_addr   = pc_q;
    assign align_fault = alignFault_q;
    assign fetch_count = fetchCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of directed vectors with hand-computed
// expected values, plus hand-written sequences for asynchronous reset and counter saturation.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] idInstr;
    logic [31:0] idPcPlus4;
    logic        idValid;
    logic        alignFault;
    logic [15:0] fetchCount;

    logic        reset2;
    logic [31:0] imemAddr2;
    logic [31:0] imemRdata2;
    logic [31:0] idInstr2;
    logic [31:0] idPcPlus42;
    logic        idValid2;
    logic        alignFault2;
    logic [3:0]  fetchCount2;

    int compared   = 0;
    int mismatched = 0;

    // The instruction ROM model returns a word that encodes its own address.
    assign imemRdata  = imemAddr ^ 32'hA5A5_0000;
    assign imemRdata2 = imemAddr2 ^ 32'hA5A5_0000;

    fetch_stage #(.RESET_PC(32'h0000_0040), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirectValid),
        .redirect_target (redirectTarget),
        .imem_addr       (imemAddr),
        .imem_rdata      (imemRdata),
        .id_instr        (idInstr),
        .id_pc_plus4     (idPcPlus4),
        .id_valid        (idValid),
        .align_fault     (alignFault),
        .fetch_count     (fetchCount)
    );

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dutSmall (
        .clk             (clk),
        .reset           (reset2),
        .stall           (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .imem_addr       (imemAddr2),
        .imem_rdata      (imemRdata2),
        .id_instr        (idInstr2),
        .id_pc_plus4     (idPcPlus42),
        .id_valid        (idValid2),
        .align_fault     (alignFault2),
        .fetch_count     (fetchCount2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] tgt);
        stall          = s;
        redirectValid  = rv;
        redirectTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid, input logic fault,
                            input logic [15:0] cnt);
        checkOutput({tag, " imem_addr"},   imemAddr,          pc);
        checkOutput({tag, " id_instr"},    idInstr,           instr);
        checkOutput({tag, " id_pc_plus4"}, idPcPlus4,         pc4);
        checkOutput({tag, " id_valid"},    {31'h0, idValid},  {31'h0, valid});
        checkOutput({tag, " align_fault"}, {31'h0, alignFault}, {31'h0, fault});
        checkOutput({tag, " fetch_count"}, {16'h0, fetchCount}, {16'h0, cnt});
    endtask

    initial begin
        //              stall rv  target        pc            instr         pc4           v  f  cnt
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0044, 32'hA5A5_0040, 32'h0000_0044, 1'b1, 1'b0, 16'd1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0048, 32'hA5A5_0044, 32'h0000_0048, 1'b1, 1'b0, 16'd2};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0000_004C, 32'hA5A5_0048, 32'h0000_004C, 1'b1, 1'b0, 16'd3};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0050, 32'hA5A5_004C, 32'h0000_0050, 1'b1, 1'b0, 16'd4};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0050, 32'hA5A5_004C, 32'h0000_0050, 1'b1, 1'b0, 16'd4};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0050, 32'hA5A5_004C, 32'h0000_0050, 1'b1, 1'b0, 16'd4};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        32'h0000_0050, 32'hA5A5_004C, 32'h0000_0050, 1'b1, 1'b0, 16'd4};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0054, 32'hA5A5_0050, 32'h0000_0054, 1'b1, 1'b0, 16'd5};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 16'd5};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0000_0204, 32'hA5A5_0200, 32'h0000_0204, 1'b1, 1'b0, 16'd6};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 16'd6};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0000_0104, 32'hA5A5_0100, 32'h0000_0104, 1'b1, 1'b1, 16'd7};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 16'd7};
        vecs[13] = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 32'h5A5A_FFFC, 32'h0000_0000, 1'b1, 1'b1, 16'd8};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'hA5A5_0000, 32'h0000_0004, 1'b1, 1'b1, 16'd9};

        reset          = 1'b0;
        reset2         = 1'b0;
        stall          = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = 32'h0;

        #12;
        checkAll("reset", 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].rv, vecs[i].tgt);
            checkAll($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                     vecs[i].valid, vecs[i].fault, vecs[i].cnt);
        end

        // The alignment fault must stay set through ten more ordinary fetches.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("fault sticky", {31'h0, alignFault}, 32'h1);
        checkOutput("count after run", {16'h0, fetchCount}, 32'd19);
        checkOutput("pc after run", imemAddr, 32'h0000_002C);

        // Assert reset between clock edges; the outputs must clear before the next edge arrives.
        redirectValid  = 1'b1;
        redirectTarget = 32'h0000_0300;
        #2;
        reset = 1'b0;
        #1;
        checkAll("async reset", 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        redirectValid  = 1'b0;
        redirectTarget = 32'h0;
        #1;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkAll("resume", 32'h0000_0044, 32'hA5A5_0040, 32'h0000_0044, 1'b1, 1'b0, 16'd1);

        // The narrow counter instance saturates instead of wrapping.
        reset2 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("small count 14", {28'h0, fetchCount2}, 32'd14);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("small count 15", {28'h0, fetchCount2}, 32'd15);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
        checkOutput("small count sat", {28'h0, fetchCount2}, 32'd15);
        checkOutput("small pc", imemAddr2, 32'h0000_0050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register and the IF/ID pipeline register.
- Drives the instruction-memory address, computes PC+4, and accepts branch/jump redirects from EX and stall requests from the hazard unit.
- Feeds the decode stage with instruction, PC+4 and a valid bit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted; must be word-aligned.
- CNT_W, 16, width of the saturating fetch counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit request; hold PC and IF/ID.
- redirect_valid  input  1  EX resolved a taken branch or jump this cycle.
- redirect_target  input  32  new fetch address when redirect_valid=1.
- imem_addr  output  32  instruction-memory address; equals the current PC (combinational).
- imem_rdata  input  32  instruction word at imem_addr; valid in the same cycle (asynchronous ROM).
- id_instr  output  32  IF/ID instruction.
- id_pc_plus4  output  32  IF/ID PC+4 of that instruction.
- id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.
- align_fault  output  1  sticky flag: a misaligned redirect target was received.
- fetch_count  output  CNT_W  number of instructions latched into IF/ID; saturating.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - PC=RESET_PC, id_instr=32'h0 (NOP), id_pc_plus4=0, id_valid=0, align_fault=0, fetch_count=0.
- First rising edge after reset deasserts fetches from RESET_PC.
- Every rising edge with reset=1 takes exactly one action, chosen by priority: redirect > stall > advance.
  - Redirect (redirect_valid=1, regardless of stall):
    - PC <= {redirect_target[31:2],2'b00}.
    - Flush IF/ID: id_valid<=0, id_instr<=0, id_pc_plus4<=0.
    - fetch_count unchanged.
    - If redirect_target[1:0]!=0, set align_fault; it stays set until reset.
  - Stall (stall=1, redirect_valid=0):
    - PC, IF/ID and fetch_count all hold.
    - imem_addr stays stable.
  - Advance (both 0):
    - PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
    - id_instr <= imem_rdata, id_pc_plus4 <= PC+4 (same modulo wrap), id_valid <= 1.
    - fetch_count increments and saturates at all-ones.
- Latency:
  - An instruction at address A appears on id_instr one edge after PC=A with no stall.
  - A redirect produces exactly one bubble cycle; the target instruction reaches IF/ID on the second edge after redirect_valid.
- imem_addr is combinational from the PC register only; it has no combinational path from stall or redirect inputs.
- Reset asserted mid-operation discards IF/ID contents and any pending redirect. No partial state survives.
- X on stall or redirect_valid while reset=1 is a bench error; the RTL does not need to handle it.

Decomposition:
- Shared package mips_pkg:
  - MIPS_NOP = 32'h0000_0000.
  - DEFAULT_RESET_PC.
  - WORD_W = 32.
  - INSTR_BYTES = 4.
- Sub-module if_id_reg holds the IF/ID register: instr, pc_plus4, valid.
  - Inputs: load, flush, hold.
  - Same clk/reset convention.
- fetch_stage holds the PC, the priority/next-PC mux, align_fault and fetch_count.

Test Plan:
- Reset with RESET_PC=32'h0000_0040; release; imem returns addr^32'hA5A5_0000 -> edge1: id_instr=32'hA5A5_0040, id_pc_plus4=0x44, id_valid=1, imem_addr=0x44; fetch_count=1.
- Straight-line run of 4 edges, then stall=1 for 3 edges -> PC, id_* and fetch_count frozen (PC=0x50, count=4); after release, fetch resumes at 0x50.
- Redirect to 0x0000_0200 while stall=1 -> next edge: PC=0x200, id_valid=0, count unchanged; following edge: id_pc_plus4=0x204, id_valid=1.
- Redirect target 0x0000_0103 -> PC=0x100, align_fault=1 and still 1 after 10 further cycles; cleared only by reset.
- Force PC to 0xFFFF_FFFC via redirect, advance twice -> PC wraps to 0x0 then 0x4; id_pc_plus4 = 0x0 for the instruction fetched at 0xFFFF_FFFC.
- Assert reset asynchronously between clock edges mid-run -> outputs return to reset values before the next edge; resume from RESET_PC; fetch_count restarts at 0. Separately, with CNT_W=4, run 20 fetches -> fetch_count=4'hF.
